fsm_flowctl: RTL
================

FSM_FLOWCTL -- requirements
Module: fsm_flowctl

Interface
REQ-001 SHALL have parameter N_CH, default 8, meaning the number of monitored FIFO channels (1..32).
REQ-002 SHALL have parameter UMBRAL_W, default 8, meaning the width of the thresholds and of each occupancy count.
REQ-003 SHALL have parameter IDLE_DLY, default 4, meaning the consecutive all-empty cycles required in ACTIVE before returning to IDLE (1..255).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port init, input, 1, threshold-load request.
REQ-007 SHALL have ports umbral_L and umbral_H, input, UMBRAL_W each, the low and high threshold candidates.
REQ-008 SHALL have port fifo_empty, input, N_CH, the per-channel empty flags.
REQ-009 SHALL have port fifo_count, input, N_CH*UMBRAL_W, the per-channel occupancy; channel i occupies bits [i*UMBRAL_W +: UMBRAL_W].
REQ-010 SHALL have port state, output, 3, the registered current state.
REQ-011 SHALL have ports umbral_L_out and umbral_H_out, output, UMBRAL_W each, the latched thresholds.
REQ-012 SHALL have port pause, output, N_CH, the registered per-channel back-pressure flags.
REQ-013 SHALL have ports idle_out, active_out and error_out, output, 1 each, the state decodes.

Function
REQ-014 SHALL use the state encoding RESET=3'b000, INIT=3'b001, IDLE=3'b010, ERROR=3'b011, ACTIVE=3'b100; any other value SHALL go to RESET on the next edge.
REQ-015 SHALL move from RESET to INIT on the first clock edge after reset deasserts.
REQ-016 In INIT with init=1, SHALL load umbral_L_out and umbral_H_out from umbral_L and umbral_H every cycle and stay in INIT.
REQ-017 In INIT with init=0, SHALL go to IDLE if umbral_L_out < umbral_H_out, else to ERROR; the thresholds SHALL NOT be loaded on that cycle.
REQ-018 In IDLE, SHALL go to INIT if init=1; otherwise go to ACTIVE if any fifo_empty bit is 0; otherwise stay in IDLE.
REQ-019 In ACTIVE, SHALL go to INIT if init=1; otherwise go to IDLE only after IDLE_DLY consecutive cycles with fifo_empty all ones.
REQ-020 The idle counter SHALL clear on any non-empty cycle, on leaving ACTIVE, and on entering ACTIVE; it SHALL saturate and never wrap.
REQ-021 In ERROR, SHALL leave only when init=1 (to INIT); error_out SHALL be 1 only in ERROR.
REQ-022 The init=1 check SHALL take priority over all FIFO conditions in IDLE, ACTIVE and ERROR.
REQ-023 In IDLE or ACTIVE, pause[i] SHALL register 1 when count_i >= umbral_H_out, register 0 when count_i <= umbral_L_out, and otherwise hold (hysteresis).
REQ-024 In RESET, INIT and ERROR, pause SHALL register all zeros.
REQ-025 idle_out SHALL equal (state==IDLE) and active_out SHALL equal (state==ACTIVE), decoded combinationally from the state register with zero latency.
REQ-026 All comparisons SHALL be unsigned over UMBRAL_W bits; the thresholds SHALL be able to hold the value 2^UMBRAL_W-1.

Reset
REQ-027 While reset=1, independent of clk: state=RESET, umbral_L_out=0, umbral_H_out=0, pause=0, idle counter=0, idle_out=0, active_out=0, error_out=0.
REQ-028 Reset asserted mid-operation (including mid-INIT or mid-idle-countdown) SHALL discard the latched thresholds and the countdown.

Structure
REQ-029 The state encodings and the default parameter values SHALL live in a shared package, fsm_flowctl_pkg.
REQ-030 The per-channel hysteresis comparator SHALL be a sub-module, pause_hyst, instantiated N_CH times via generate.

Verification
REQ-031 Reset, then init=1 for 2 cycles with L=4, H=12, then init=0 -> umbral outputs 4/12 and the sequence INIT->IDLE, idle_out=1.
REQ-032 INIT with L=12, H=12, then init=0 -> ERROR, error_out=1, pause=0; then init=1 -> INIT on the next edge.
REQ-033 IDLE; clear fifo_empty[3] for 1 cycle -> ACTIVE; all empty for 3 cycles, one non-empty, then 4 empty -> IDLE exactly 4 cycles after the last non-empty.
REQ-034 ACTIVE with L=4, H=12; ch0 count sweeps 0,11,12,8,5,4,3 -> pause[0] = 0,0,1,1,1,0,0, each registered one cycle after its count.
REQ-035 Assert reset asynchronously mid-ACTIVE with pause=8'hFF -> all outputs zero before the next clk edge; after release, RESET->INIT.
REQ-036 Thresholds L=0, H=8'hFF with count=8'hFF -> pause set; count=0 -> pause cleared; no wrap or overflow.

Source files
------------

// File: rtl/fsm_flowctl_pkg.sv
// Shared state encoding and default parameters for the FIFO flow-control FSM.
package fsm_flowctl_pkg;

  localparam int N_CH_DEF     = 8;
  localparam int UMBRAL_W_DEF = 8;
  localparam int IDLE_DLY_DEF = 4;
  // Wide enough for the largest supported idle delay (255).
  localparam int IDLE_CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_RESET  = 3'b000,
    ST_INIT   = 3'b001,
    ST_IDLE   = 3'b010,
    ST_ERROR  = 3'b011,
    ST_ACTIVE = 3'b100
  } state_t;

endpackage

// File: rtl/pause_hyst.sv
// Per-channel back-pressure flag with hysteresis between the low and high thresholds.
module pause_hyst #(
  parameter int W = fsm_flowctl_pkg::UMBRAL_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] count,
  input  logic [W-1:0] umbral_L,
  input  logic [W-1:0] umbral_H,
  output logic         pause
);

  // Outside IDLE/ACTIVE the flag is forced low; in between thresholds it holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pause <= 1'b0;
    end else if (!en) begin
      pause <= 1'b0;
    end else if (count >= umbral_H) begin
      pause <= 1'b1;
    end else if (count <= umbral_L) begin
      pause <= 1'b0;
    end
  end

endmodule

// File: rtl/fsm_flowctl.sv
// FIFO flow-control sequencer: threshold load, idle/active tracking and
// per-channel hysteresis back-pressure.
//
//   state  | meaning
//   RESET  | post-reset, moves to INIT on the first edge
//   INIT   | loading thresholds while init=1, then validates L < H
//   IDLE   | all FIFOs empty, waiting for traffic
//   ERROR  | invalid thresholds, waits for init=1
//   ACTIVE | traffic present; returns to IDLE after IDLE_DLY empty cycles
module fsm_flowctl
  import fsm_flowctl_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int UMBRAL_W = UMBRAL_W_DEF,
  parameter int IDLE_DLY = IDLE_DLY_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic [UMBRAL_W-1:0]      umbral_L,
  input  logic [UMBRAL_W-1:0]      umbral_H,
  input  logic [N_CH-1:0]          fifo_empty,
  input  logic [N_CH*UMBRAL_W-1:0] fifo_count,
  output logic [2:0]               state,
  output logic [UMBRAL_W-1:0]      umbral_L_out,
  output logic [UMBRAL_W-1:0]      umbral_H_out,
  output logic [N_CH-1:0]          pause,
  output logic                     idle_out,
  output logic                     active_out,
  output logic                     error_out
);

  localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(IDLE_DLY - 1);

  state_t                  state_q, state_d;
  logic [UMBRAL_W-1:0]     thr_l, thr_h;
  logic                    load_thr;
  logic [IDLE_CNT_W-1:0]   idle_cnt, idle_cnt_d;
  logic                    all_empty;
  logic                    idle_done;
  logic                    hyst_en;

  assign all_empty = &fifo_empty;
  assign idle_done = (idle_cnt >= IDLE_LAST);

  // Counter defaults to zero, which covers clearing on entry to and exit from ACTIVE.
  always_comb begin
    state_d    = ST_RESET;
    idle_cnt_d = '0;
    load_thr   = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (init) begin
          state_d  = ST_INIT;
          load_thr = 1'b1;
        end else if (thr_l < thr_h) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERROR;
        end
      end
      ST_IDLE: begin
        if (init)            state_d = ST_INIT;
        else if (!all_empty) state_d = ST_ACTIVE;
        else                 state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (init) begin
          state_d = ST_INIT;
        end else if (!all_empty) begin
          state_d = ST_ACTIVE;
        end else if (idle_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_ACTIVE;
          idle_cnt_d = (idle_cnt == '1) ? idle_cnt : idle_cnt + 1'b1;
        end
      end
      ST_ERROR: begin
        if (init) state_d = ST_INIT;
        else      state_d = ST_ERROR;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RESET;
      idle_cnt <= '0;
    end else begin
      state_q  <= state_d;
      idle_cnt <= idle_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_l <= '0;
      thr_h <= '0;
    end else if (load_thr) begin
      thr_l <= umbral_L;
      thr_h <= umbral_H;
    end
  end

  assign hyst_en = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pause_hyst #(.W(UMBRAL_W)) u_hyst (
      .clk      (clk),
      .reset    (reset),
      .en       (hyst_en),
      .count    (fifo_count[i*UMBRAL_W +: UMBRAL_W]),
      .umbral_L (thr_l),
      .umbral_H (thr_h),
      .pause    (pause[i])
    );
  end

  assign state        = state_q;
  assign umbral_L_out = thr_l;
  assign umbral_H_out = thr_h;
  assign idle_out     = (state_q == ST_IDLE);
  assign active_out   = (state_q == ST_ACTIVE);
  assign error_out    = (state_q == ST_ERROR);

endmodule
